// File: rtl/tcp_tx_framer.sv
// tcp_tx_framer: TCP header + payload framer with payload FIFO; define TCP_SEQ_AUTO_EN to advance seq per packet
module tcp_tx_framer #(
  parameter logic [15:0] SRC_PORT = 16'h0400,
  parameter logic [15:0] WIN_SIZE = 16'h0400,
  parameter logic [31:0] SEQ_INIT = 32'h55bc55bc,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_ip_addr,
  input  logic [15:0] cmd_dest_port,
  input  logic [7:0]  cmd_flags,
  input  logic [31:0] cmd_ack,
  input  logic [15:0] cmd_length,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] tcp_data,
  output logic        tcp_valid,
  input  logic        tcp_ready,
  output logic        tcp_sop,
  output logic        tcp_eop,
  output logic [31:0] ip_addr_out,
  output logic [15:0] tcp_length_out,
  output logic        len_err,
  output logic [31:0] seq_out
);
  localparam logic [1:0] IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;
  logic [1:0] state;
  logic [2:0] hidx;
  logic [16:0] cnt, nwords;
  logic [15:0] dest_port, len_q;
  logic [7:0] flags;
  logic [31:0] ack, seq;
  logic [32:0] mem [2**FIFO_AW];
  logic [32:0] head;
  logic [FIFO_AW:0] wp, rp;
  logic empty, full, push, pop, xfer;
  assign nwords = ({1'b0, len_q} + 17'd3) >> 2;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {FIFO_AW{1'b0}}};
  assign in_ready = !reset && !full;
  assign cmd_ready = !reset && state == IDLE;
  assign push = in_valid && in_ready;
  assign head = mem[rp[FIFO_AW-1:0]];
  assign tcp_valid = state == HDR || (state == PAY && !empty);
  assign xfer = tcp_valid && tcp_ready;
  assign pop = xfer && state == PAY;
  assign tcp_sop = state == HDR && hidx == 3'd0;
  assign tcp_eop = state == HDR ? (hidx == 3'd4 && nwords == 17'd0) : (state == PAY && cnt == 17'd1);
  assign seq_out = seq;
  assign tcp_data = state == PAY ? head[31:0] :
                    state != HDR ? 32'h0 :
                    hidx == 3'd0 ? {SRC_PORT, dest_port} :
                    hidx == 3'd1 ? seq :
                    hidx == 3'd2 ? ack :
                    hidx == 3'd3 ? {4'h5, 4'h0, flags, WIN_SIZE} : 32'h0;
  // payload storage; in_last rides along as bit 32 for length checking
  always_ff @(posedge clk)
    if (push) mem[wp[FIFO_AW-1:0]] <= {in_last, in_data};
  // FIFO pointers, one extra bit distinguishes full from empty
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop) rp <= rp + PTR_ONE;
    end
  // command latch, header/payload sequencing and length-mismatch tracking
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      hidx <= '0;
      cnt <= '0;
      dest_port <= '0;
      len_q <= '0;
      flags <= '0;
      ack <= '0;
      ip_addr_out <= '0;
      tcp_length_out <= '0;
      len_err <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        ip_addr_out <= cmd_ip_addr;
        dest_port <= cmd_dest_port;
        flags <= cmd_flags;
        ack <= cmd_ack;
        len_q <= cmd_length;
        tcp_length_out <= cmd_length + 16'd20;
        len_err <= 1'b0;
        hidx <= '0;
        state <= HDR;
      end
      if (state == HDR && xfer) begin
        hidx <= hidx + 3'd1;
        if (hidx == 3'd4) begin
          state <= nwords == 17'd0 ? IDLE : PAY;
          cnt <= nwords;
        end
      end
      if (pop) begin
        cnt <= cnt - 17'd1;
        if (head[32] != (cnt == 17'd1)) len_err <= 1'b1;
        if (cnt == 17'd1) state <= IDLE;
      end
    end
`ifdef TCP_SEQ_AUTO_EN
  // advance by payload bytes plus one for each of SYN and FIN once the packet leaves
  always_ff @(posedge clk or posedge reset)
    if (reset) seq <= SEQ_INIT;
    else if (xfer && tcp_eop) seq <= seq + {16'h0, len_q} + {31'h0, flags[1]} + {31'h0, flags[0]};
`else
  assign seq = SEQ_INIT;
`endif
endmodule

// File: tb/tb_tcp_tx_framer.sv
// tb_tcp_tx_framer: directed scenarios for tcp_tx_framer with a 4-deep payload FIFO
module tb_tcp_tx_framer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_ip_addr = '0, cmd_ack = '0;
  logic [15:0] cmd_dest_port = '0, cmd_length = '0;
  logic [7:0] cmd_flags = '0;
  logic [31:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [31:0] tcp_data, ip_addr_out, seq_out;
  logic tcp_valid, tcp_sop, tcp_eop, len_err;
  logic tcp_ready = 1'b0;
  logic [15:0] tcp_length_out;
  int vectors = 0, errors = 0, got = 0, stab_bad = 0;
  logic [31:0] gd [32];
  logic gs [32];
  logic ge [32];
  logic [31:0] exp_seq = 32'h55bc55bc;

  always #5 clk = ~clk;

  tcp_tx_framer #(.FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ip_addr(cmd_ip_addr), .cmd_dest_port(cmd_dest_port), .cmd_flags(cmd_flags),
    .cmd_ack(cmd_ack), .cmd_length(cmd_length), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .tcp_data(tcp_data), .tcp_valid(tcp_valid),
    .tcp_ready(tcp_ready), .tcp_sop(tcp_sop), .tcp_eop(tcp_eop), .ip_addr_out(ip_addr_out),
    .tcp_length_out(tcp_length_out), .len_err(len_err), .seq_out(seq_out)
  );

  task automatic push(input logic [31:0] d, input logic l);
    @(negedge clk);
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] ip, input logic [15:0] port, input logic [7:0] fl,
                          input logic [31:0] ak, input logic [15:0] len);
    @(negedge clk);
    cmd_ip_addr = ip;
    cmd_dest_port = port;
    cmd_flags = fl;
    cmd_ack = ak;
    cmd_length = len;
    cmd_valid = 1'b1;
    vectors++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready got %b exp 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit tog);
    logic hv, hs, he;
    logic [31:0] hd;
    hv = 1'b0;
    got = 0;
    for (int c = 0; c < 300 && got < n; c++) begin
      tcp_ready = tog ? ((c % 2) == 1) : 1'b1;
      if (hv && (tcp_valid !== 1'b1 || tcp_data !== hd || tcp_sop !== hs || tcp_eop !== he)) stab_bad++;
      hv = tcp_valid && !tcp_ready;
      hd = tcp_data;
      hs = tcp_sop;
      he = tcp_eop;
      if (tcp_valid && tcp_ready) begin
        gd[got] = tcp_data;
        gs[got] = tcp_sop;
        ge[got] = tcp_eop;
        got++;
      end
      @(negedge clk);
    end
    tcp_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, in_ready, tcp_valid, tcp_sop, tcp_eop, len_err} !== 6'b0 || tcp_data !== 32'h0 ||
        ip_addr_out !== 32'h0 || tcp_length_out !== 16'h0 || seq_out !== 32'h55bc55bc) begin
      errors++;
      $display("FAIL reset outputs got rdy%b%b v%b data %h ip %h len %h err %b seq %h", cmd_ready, in_ready,
               tcp_valid, tcp_data, ip_addr_out, tcp_length_out, len_err, seq_out);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post-reset ready got %b%b exp 11", cmd_ready, in_ready);
    end
  endtask

  task automatic test_basic(input bit tog, input string nm);
    logic [31:0] ed [7];
    ed = '{32'h04001F90, exp_seq, 32'hbc55bc55, 32'h50180400, 32'h0, 32'h11111111, 32'h22222222};
    stab_bad = 0;
    push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b1);
    send_cmd(32'h0A000001, 16'h1F90, 8'h18, 32'hbc55bc55, 16'd8);
    collect(7, tog);
    vectors++;
    if (got != 7) begin errors++; $display("FAIL %s count got %0d exp 7", nm, got); end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (gd[i] !== ed[i] || gs[i] !== (i == 0) || ge[i] !== (i == 6)) begin
        errors++;
        $display("FAIL %s word%0d got %h sop%b eop%b exp %h", nm, i, gd[i], gs[i], ge[i], ed[i]);
      end
    end
    vectors++;
    if (tcp_length_out !== 16'd28 || ip_addr_out !== 32'h0A000001 || len_err !== 1'b0) begin
      errors++; $display("FAIL %s fields got len %0d ip %h err %b exp 28 0a000001 0", nm, tcp_length_out, ip_addr_out, len_err);
    end
    vectors++;
    if (tcp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle gap got v%b rdy%b exp 0 1", nm, tcp_valid, cmd_ready);
    end
    vectors++;
    if (stab_bad != 0) begin errors++; $display("FAIL %s stall stability got %0d changes exp 0", nm, stab_bad); end
`ifdef TCP_SEQ_AUTO_EN
    exp_seq = exp_seq + 32'd8;
`endif
    vectors++;
    if (seq_out !== exp_seq) begin errors++; $display("FAIL %s seq got %h exp %h", nm, seq_out, exp_seq); end
  endtask

  task automatic test_len_err;
    push(32'hAAAA0001, 1'b1);
    push(32'hBB000000, 1'b0);
    send_cmd(32'h0A000002, 16'h0017, 8'h18, 32'h1, 16'd5);
    collect(7, 1'b0);
    vectors++;
    if (got != 7 || gd[5] !== 32'hAAAA0001 || gd[6] !== 32'hBB000000 || ge[5] !== 1'b0 || ge[6] !== 1'b1) begin
      errors++;
      $display("FAIL len_err framing got n%0d %h %h eop%b%b exp 7 aaaa0001 bb000000 01", got, gd[5], gd[6], ge[5], ge[6]);
    end
    vectors++;
    if (tcp_length_out !== 16'd25) begin errors++; $display("FAIL len_err tcp_length got %0d exp 25", tcp_length_out); end
    repeat (3) @(negedge clk);
    vectors++;
    if (len_err !== 1'b1) begin errors++; $display("FAIL len_err sticky got %b exp 1", len_err); end
`ifdef TCP_SEQ_AUTO_EN
    exp_seq = exp_seq + 32'd5;
`endif
  endtask

  task automatic test_syn;
    logic [31:0] ed [5];
    ed = '{32'h04000050, exp_seq, 32'h12345678, 32'h50020400, 32'h0};
    send_cmd(32'h0A000003, 16'h0050, 8'h02, 32'h12345678, 16'd0);
    vectors++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL syn len_err clear got %b exp 0", len_err); end
    collect(5, 1'b0);
    vectors++;
    if (got != 5) begin errors++; $display("FAIL syn count got %0d exp 5", got); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (gd[i] !== ed[i] || gs[i] !== (i == 0) || ge[i] !== (i == 4)) begin
        errors++;
        $display("FAIL syn word%0d got %h sop%b eop%b exp %h", i, gd[i], gs[i], ge[i], ed[i]);
      end
    end
`ifdef TCP_SEQ_AUTO_EN
    exp_seq = exp_seq + 32'd1;
`endif
    vectors++;
    if (seq_out !== exp_seq || tcp_length_out !== 16'd20 || tcp_valid !== 1'b0) begin
      errors++; $display("FAIL syn after got seq %h len %0d v%b exp %h 20 0", seq_out, tcp_length_out, tcp_valid, exp_seq);
    end
  endtask

  task automatic test_fifo_full;
    logic [31:0] ed [11];
    ed = '{32'h04000050, exp_seq, 32'h00000001, 32'h50100400, 32'h0,
           32'hF0000000, 32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004, 32'hF0000005};
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL fill in_ready word%0d got %b exp 1", k, in_ready); end
      push(32'hF0000000 + k, 1'b0);
    end
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full in_ready got %b exp 0", in_ready); end
    in_data = 32'hF0000004;
    in_last = 1'b0;
    in_valid = 1'b1;
    send_cmd(32'hC0A80001, 16'h0050, 8'h10, 32'h1, 16'd24);
    fork
      collect(11, 1'b0);
      begin
        for (int k = 4; k < 6; k++) begin
          in_data = 32'hF0000000 + k;
          in_last = k == 5;
          in_valid = 1'b1;
          for (int b = 0; b < 100 && in_ready !== 1'b1; b++) @(negedge clk);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
    join
    vectors++;
    if (got != 11) begin errors++; $display("FAIL fifo count got %0d exp 11", got); end
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (gd[i] !== ed[i] || ge[i] !== (i == 10)) begin
        errors++; $display("FAIL fifo word%0d got %h eop%b exp %h", i, gd[i], ge[i], ed[i]);
      end
    end
    vectors++;
    if (in_ready !== 1'b1 || len_err !== 1'b0 || tcp_length_out !== 16'd44) begin
      errors++; $display("FAIL fifo after got in_ready %b err %b len %0d exp 1 0 44", in_ready, len_err, tcp_length_out);
    end
`ifdef TCP_SEQ_AUTO_EN
    exp_seq = exp_seq + 32'd24;
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] ed [6];
    for (int k = 0; k < 4; k++) push(32'hC0DE0000 + k, k == 3);
    send_cmd(32'h0A000004, 16'h0099, 8'h18, 32'h5, 16'd16);
    collect(6, 1'b0);
    vectors++;
    if (got != 6 || gd[5] !== 32'hC0DE0000) begin errors++; $display("FAIL abort pre got n%0d %h exp 6 c0de0000", got, gd[5]); end
    reset = 1'b1;
    #1;
    vectors++;
    if ({cmd_ready, in_ready, tcp_valid, tcp_sop, tcp_eop, len_err} !== 6'b0 || tcp_data !== 32'h0 ||
        ip_addr_out !== 32'h0 || tcp_length_out !== 16'h0 || seq_out !== 32'h55bc55bc) begin
      errors++;
      $display("FAIL abort outputs got v%b eop%b data %h ip %h len %h seq %h", tcp_valid, tcp_eop, tcp_data,
               ip_addr_out, tcp_length_out, seq_out);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_seq = 32'h55bc55bc;
    @(negedge clk);
    vectors++;
    if (tcp_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort idle got v%b in_ready %b exp 0 1", tcp_valid, in_ready);
    end
    ed = '{32'h04001234, exp_seq, 32'h7, 32'h50180400, 32'h0, 32'hDEADBEEF};
    push(32'hDEADBEEF, 1'b1);
    send_cmd(32'h0A000005, 16'h1234, 8'h18, 32'h7, 16'd4);
    collect(6, 1'b0);
    vectors++;
    if (got != 6) begin errors++; $display("FAIL recover count got %0d exp 6", got); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (gd[i] !== ed[i] || gs[i] !== (i == 0) || ge[i] !== (i == 5)) begin
        errors++; $display("FAIL recover word%0d got %h sop%b eop%b exp %h", i, gd[i], gs[i], ge[i], ed[i]);
      end
    end
    vectors++;
    if (tcp_valid !== 1'b0 || len_err !== 1'b0) begin
      errors++; $display("FAIL recover tail got v%b err %b exp 0 0", tcp_valid, len_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0, "basic");
    test_basic(1'b1, "toggle");
    test_len_err();
    test_syn();
    test_fifo_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/tcp_tx_framer.md
Name: tcp_tx_framer

Overview:
- Next-generation TCP transmit framer.
- Accepts a per-packet command (IP address, destination port, flags, ack number, payload length) plus a 32-bit payload stream, buffered in an internal parametrised FIFO.
- Emits a 20-byte TCP header followed by the payload on a valid/ready output with sop/eop markers.
- Tracks the sequence number across packets; sits between the software app interface and the IP encapsulation stage.

Parameters:
- SRC_PORT, 16'h0400, source port placed in header word 0.
- WIN_SIZE, 16'h0400, window field of header word 3.
- SEQ_INIT, 32'h55bc55bc, sequence number after reset.
- FIFO_AW, 4, payload FIFO address width; depth = 2**FIFO_AW words.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_ip_addr  in  32  destination IP address
- cmd_dest_port  in  16  destination port
- cmd_flags  in  8  TCP flags {CWR,ECE,URG,ACK,PSH,RST,SYN,FIN}
- cmd_ack  in  32  acknowledgement number
- cmd_length  in  16  payload length in bytes
- in_data  in  32  payload word, big-endian byte order
- in_valid  in  1  payload word valid
- in_last  in  1  last payload word of packet
- in_ready  out  1  FIFO not full
- tcp_data  out  32  output word
- tcp_valid  out  1  output word valid
- tcp_ready  in  1  downstream accepts word
- tcp_sop  out  1  first header word
- tcp_eop  out  1  final word of packet
- ip_addr_out  out  32  latched cmd_ip_addr, stable for the whole packet
- tcp_length_out  out  16  cmd_length + 20, stable for the whole packet
- len_err  out  1  sticky payload/length mismatch flag
- seq_out  out  32  current sequence register

Behaviour:
- Reset values:
  - all outputs 0 except seq_out = SEQ_INIT
  - FIFO flushed; FSM in IDLE
- Reset mid-packet aborts the packet immediately, with no eop.
- Payload FIFO:
  - in_ready = !full.
  - Writes occur on in_valid && in_ready, independent of FSM state, so the payload may precede or follow its command.
  - in_valid while full: word is not written and must be held by upstream.
- Word count:
  - nwords = (cmd_length + 3) >> 2, 17-bit intermediate.
  - Trailing unused bytes of the last word are passed through untouched.
- FSM states: IDLE, HDR, PAY.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch all cmd_* fields; tcp_length_out = cmd_length + 20 (16-bit, wraps); clear len_err; go to HDR with hidx = 0.
  - First header word is valid the next cycle.
- HDR: tcp_valid = 1; hidx advances on tcp_valid && tcp_ready.
  - Word 0: {SRC_PORT, dest_port}; tcp_sop = 1.
  - Word 1: seq.
  - Word 2: ack.
  - Word 3: {4'h5, 3'b000, 1'b0, flags, WIN_SIZE}.
  - Word 4: {16'h0000 checksum, 16'h0000 urgent pointer}.
  - After word 4: if nwords == 0, tcp_eop = 1 on word 4 and the FSM returns to IDLE; else go to PAY with the word counter at nwords.
- PAY:
  - tcp_valid = !fifo_empty; tcp_data = FIFO head.
  - FIFO pops on tcp_valid && tcp_ready.
  - tcp_eop = 1 on the word with counter == 1; the FSM returns to IDLE after that transfer.
  - Empty FIFO: tcp_valid = 0 (bubble); the counter holds.
- Output stability: tcp_valid, tcp_data, tcp_sop and tcp_eop hold stable while tcp_valid && !tcp_ready.
- len_err:
  - Set if a popped word has in_last = 1 while the counter != 1, or in_last = 0 while the counter == 1 (last bit stored in FIFO, 33 bits wide).
  - Packet framing always follows cmd_length.
- Back-to-back packets: one IDLE cycle between eop and the next sop.
- Throughput: one word per cycle while tcp_ready = 1 and the FIFO is non-empty.

Optional Feature:
- Macro: TCP_SEQ_AUTO_EN.
- Defined: at the eop transfer, seq += cmd_length + (SYN ? 1 : 0) + (FIN ? 1 : 0), mod 2^32 wrap.
- Undefined: seq stays at SEQ_INIT for every packet; seq_out constant.

Test Plan:
1. Command {ip=0x0A000001, port=0x1F90, flags=0x18, ack=0xbc55bc55, len=8}, then payload 0x11111111 and 0x22222222 (last on 2nd), tcp_ready=1 -> 7 words: 0x04001F90, 0x55bc55bc, 0xbc55bc55, 0x50180400, 0x00000000, 0x11111111, 0x22222222; sop on word 0, eop on word 6; tcp_length_out=28.
2. Flags-only command (flags=0x02 SYN, len=0) -> 5 header words, eop on word 4, word 3 = 0x50020400; with TCP_SEQ_AUTO_EN, seq_out = 0x55bc55bd afterwards.
3. FIFO_AW=2: push 6 words before any command -> in_ready low after 4; after a command with len=24, all 6 words emerge in order and in_ready reasserts.
4. tcp_ready toggling every other cycle through scenario 1 -> identical word sequence, outputs stable during stalls, no duplicates or drops.
5. len=5 but in_last asserted on the 1st word -> 2 payload words emitted, eop on the 2nd, len_err = 1 until the next command accept.
6. Reset asserted during payload word 1 of a 4-word packet -> all outputs 0 at once, FIFO empty, seq_out = SEQ_INIT; a following command frames correctly.
